// File: rtl/bus_arbiter_mux_pkg.sv
// Shared widths, constants and state type for the shared-bus arbiter/mux.
// Build-wide bus widths can be overridden by defining BUS_ADDR / BUS_DATA.
`ifndef BUS_ADDR
`define BUS_ADDR 32
`endif
`ifndef BUS_DATA
`define BUS_DATA 32
`endif

package bus_arbiter_mux_pkg;

  localparam int unsigned BUS_ADDR_W = `BUS_ADDR;
  localparam int unsigned BUS_DATA_W = `BUS_DATA;

  localparam logic                  EN        = 1'b1;
  localparam logic                  DIS_EN    = 1'b0;
  localparam logic [BUS_DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Index width that stays legal when there is only one master.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_mux_rr_pick.sv
// Combinational round-robin picker: lowest asserted request strictly above
// last_i wins, wrapping to the lowest asserted request overall.
module bus_arbiter_mux_rr_pick #(
  parameter int unsigned NUM_M = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [PTR_W-1:0] last_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic             vld_o
);

  logic [NUM_M-1:0] above;
  logic [NUM_M-1:0] masked;
  logic [NUM_M-1:0] pool;

  always_comb begin
    above  = ~({NUM_M{1'b1}} >> (NUM_M - 1 - 32'(last_i)));
    masked = req_i & above;
    pool   = (|masked) ? masked : req_i;
    // x & -x isolates the lowest set bit
    gnt_o  = pool & (~pool + NUM_M'(1));
    vld_o  = |req_i;
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// N-master shared-bus front end: registered round-robin grant held for the
// whole ownership period, plus an AND-OR mux from the owner to the slave.
module bus_arbiter_mux
  import bus_arbiter_mux_pkg::*;
#(
  parameter int unsigned NUM_M  = 4,
  parameter int unsigned ADDR_W = BUS_ADDR_W,
  parameter int unsigned DATA_W = BUS_DATA_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_M-1:0]            m_req_i,
  input  logic [NUM_M*ADDR_W-1:0]     m_addr_i,
  input  logic [NUM_M*DATA_W-1:0]     m_wr_data_i,
  input  logic [NUM_M-1:0]            m_we_i,
  input  logic [NUM_M*(DATA_W/8)-1:0] m_sel_i,
  input  logic [NUM_M-1:0]            m_as_i,
  output logic [NUM_M-1:0]            m_grant_o,
  output logic [NUM_M-1:0]            m_rdy_o,
  output logic [DATA_W-1:0]           m_rd_data_o,
  output logic [ADDR_W-1:0]           s_addr_o,
  output logic [DATA_W-1:0]           s_wr_data_o,
  output logic                        s_we_o,
  output logic [DATA_W/8-1:0]         s_sel_o,
  output logic                        s_as_o,
  input  logic [DATA_W-1:0]           s_rd_data_i,
  input  logic                        s_rdy_i
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned PTR_W = ptr_w(NUM_M);

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] last_q, last_d;
  logic [PTR_W-1:0] owner_idx, pick_last;
  logic [NUM_M-1:0] pick_gnt;
  logic             pick_vld;
  logic             owner_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= PTR_W'(NUM_M - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_M; i++)
      owner_idx |= grant_q[i] ? PTR_W'(i) : '0;
  end

  assign owner_req = |(m_req_i & grant_q);
  // On release the pointer must already reflect the outgoing owner.
  assign pick_last = (state_q == OWN) ? owner_idx : last_q;

  bus_arbiter_mux_rr_pick #(
    .NUM_M (NUM_M),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i  (m_req_i),
    .last_i (pick_last),
    .gnt_o  (pick_gnt),
    .vld_o  (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = OWN;
          grant_d = pick_gnt;
        end
      end
      OWN: begin
        if (!owner_req) begin
          last_d = owner_idx;
          if (pick_vld) begin
            grant_d = pick_gnt;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    s_addr_o    = '0;
    s_wr_data_o = '0;
    s_we_o      = DIS_EN;
    s_sel_o     = '0;
    s_as_o      = DIS_EN;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      s_addr_o    |= {ADDR_W{grant_q[i]}} & m_addr_i[i*ADDR_W +: ADDR_W];
      s_wr_data_o |= {DATA_W{grant_q[i]}} & m_wr_data_i[i*DATA_W +: DATA_W];
      s_sel_o     |= {SEL_W{grant_q[i]}} & m_sel_i[i*SEL_W +: SEL_W];
      s_we_o      |= grant_q[i] & m_we_i[i];
      s_as_o      |= grant_q[i] & m_as_i[i];
    end
    m_grant_o   = grant_q;
    m_rdy_o     = {NUM_M{s_rdy_i}} & grant_q;
    m_rd_data_o = (|grant_q) ? s_rd_data_i : DATA_W'(ZERO_WORD);
  end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: directed scenarios plus randomized traffic
// checked against an integer-level round-robin ownership model.
module tb_bus_arbiter_mux;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]    m_req, m_we, m_as;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wr_data;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_grant, m_rdy;
  logic [DW-1:0]   m_rd_data, s_wr_data, s_rd_data;
  logic [AW-1:0]   s_addr;
  logic            s_we, s_as, s_rdy;
  logic [SW-1:0]   s_sel;

  logic          req1, we1, as1, grant1, rdy1, s_we1, s_as1;
  logic [AW-1:0] addr1, s_addr1;
  logic [DW-1:0] wdat1, rdat1, s_wdat1;
  logic [SW-1:0] sel1, s_sel1;

  int tests = 0;
  int fails = 0;
  int exp_owner;
  int exp_last;

  always #5 clk = ~clk;

  bus_arbiter_mux #(.NUM_M(N), .ADDR_W(AW), .DATA_W(DW)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_wr_data_i(m_wr_data),
    .m_we_i(m_we), .m_sel_i(m_sel), .m_as_i(m_as),
    .m_grant_o(m_grant), .m_rdy_o(m_rdy), .m_rd_data_o(m_rd_data),
    .s_addr_o(s_addr), .s_wr_data_o(s_wr_data), .s_we_o(s_we),
    .s_sel_o(s_sel), .s_as_o(s_as),
    .s_rd_data_i(s_rd_data), .s_rdy_i(s_rdy)
  );

  bus_arbiter_mux #(.NUM_M(1), .ADDR_W(AW), .DATA_W(DW)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .m_req_i(req1), .m_addr_i(addr1), .m_wr_data_i(wdat1),
    .m_we_i(we1), .m_sel_i(sel1), .m_as_i(as1),
    .m_grant_o(grant1), .m_rdy_o(rdy1), .m_rd_data_o(rdat1),
    .s_addr_o(s_addr1), .s_wr_data_o(s_wdat1), .s_we_o(s_we1),
    .s_sel_o(s_sel1), .s_as_o(s_as1),
    .s_rd_data_i(s_rd_data), .s_rdy_i(s_rdy)
  );

  // Ownership model: the owner keeps the bus while requesting; otherwise the
  // next requester after the most recent owner (mod N) takes it.
  function automatic void model_reset();
    exp_owner = -1;
    exp_last  = N - 1;
  endfunction

  function automatic void model_step(input logic [N-1:0] req);
    if (exp_owner >= 0 && req[exp_owner]) return;
    if (exp_owner >= 0) exp_last = exp_owner;
    exp_owner = -1;
    for (int k = 1; k <= N; k++) begin
      if (req[(exp_last + k) % N]) begin
        exp_owner = (exp_last + k) % N;
        break;
      end
    end
  endfunction

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g = '0;
    if (exp_owner >= 0) g[exp_owner] = 1'b1;
    return g;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] g);
    int r = -1;
    for (int i = 0; i < N; i++) if (g[i]) r = i;
    return r;
  endfunction

  // One clock edge; model consumes the requests present at that edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step(m_req);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_req = '0;
    m_as  = '0;
    s_rdy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    m_addr = {$urandom, $urandom, $urandom, $urandom};
    m_as   = '1;
    m_req  = '0;
    rst_n  = 1'b0;
    #3;
    tests++;
    if (m_grant !== '0 || s_as !== 1'b0) begin
      fails++;
      $display("FAIL reset_async grant=%b s_as=%b want 0000/0", m_grant, s_as);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 10; c++) begin
      cycle();
      tests++;
      if (m_grant !== '0 || s_as !== 1'b0 || s_addr !== '0) begin
        fails++;
        $display("FAIL reset_idle c=%0d grant=%b s_as=%b s_addr=%h want 0", c, m_grant, s_as, s_addr);
      end
    end
  endtask

  task automatic test_two_req();
    logic [AW-1:0] a0;
    do_reset();
    m_addr = {$urandom, $urandom, $urandom, $urandom};
    a0 = m_addr[AW-1:0];
    m_req = 4'b0101;
    cycle();
    tests++;
    if (m_grant !== 4'b0001) begin
      fails++;
      $display("FAIL two_req_grant got=%b want=0001", m_grant);
    end
    tests++;
    if (s_addr !== a0) begin
      fails++;
      $display("FAIL two_req_addr got=%h want=%h", s_addr, a0);
    end
    s_rdy = 1'b1;
    #1;
    tests++;
    if (m_rdy !== 4'b0001) begin
      fails++;
      $display("FAIL two_req_rdy got=%b want=0001", m_rdy);
    end
    s_rdy = 1'b0;
  endtask

  task automatic test_handoff();
    int seq[$];
    int held = 0;
    int prev = -1;
    int own;
    int gaps = 0;
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    m_req = 4'b1111;
    for (int c = 0; c < 40 && seq.size() < 5; c++) begin
      cycle();
      tests++;
      if (m_grant !== exp_grant()) begin
        fails++;
        $display("FAIL handoff_model c=%0d got=%b want=%b", c, m_grant, exp_grant());
      end
      if (m_grant == '0) gaps++;
      own = onehot_idx(m_grant);
      if (own != prev) begin
        seq.push_back(own);
        held = 1;
        prev = own;
      end else begin
        held++;
      end
      m_req = 4'b1111;
      if (held == 3 && own >= 0) m_req[own] = 1'b0;
    end
    tests++;
    if (gaps != 0) begin
      fails++;
      $display("FAIL handoff_gap idle_cycles=%0d want=0", gaps);
    end
    tests++;
    if (seq.size() < 5) begin
      fails++;
      $display("FAIL handoff_timeout owners_seen=%0d want=5", seq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (seq[i] != want[i]) begin
          fails++;
          $display("FAIL handoff_order pos=%0d got=%0d want=%0d", i, seq[i], want[i]);
          break;
        end
      end
    end
    m_req = '0;
  endtask

  task automatic test_single_master();
    do_reset();
    m_we  = '0;
    m_req = 4'b0010;
    cycle();
    tests++;
    if (m_grant !== 4'b0010) begin
      fails++;
      $display("FAIL single_grant got=%b want=0010", m_grant);
    end
    for (int r = 0; r < 2; r++) begin
      m_as[1] = 1'b1;
      m_addr[AW +: AW] = $urandom;
      s_rdy = 1'b0;
      cycle();
      s_rdy     = 1'b1;
      s_rd_data = 32'hDEAD_BEEF;
      #1;
      tests++;
      if (m_rd_data !== 32'hDEAD_BEEF || m_rdy !== 4'b0010 || s_as !== 1'b1) begin
        fails++;
        $display("FAIL single_read r=%0d rd=%h rdy=%b as=%b want deadbeef/0010/1", r, m_rd_data, m_rdy, s_as);
      end
      cycle();
      s_rdy   = 1'b0;
      m_as[1] = 1'b0;
    end
    m_req = '0;
    cycle();
    tests++;
    if (m_grant !== '0 || m_rd_data !== '0) begin
      fails++;
      $display("FAIL single_release grant=%b rd=%h want 0000/0", m_grant, m_rd_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_req = 4'b0100;
    cycle();
    m_as = 4'b0100;
    #1;
    tests++;
    if (s_as !== 1'b1) begin
      fails++;
      $display("FAIL midrst_pre s_as=%b want=1", s_as);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (m_grant !== '0 || s_as !== 1'b0) begin
      fails++;
      $display("FAIL midrst_drop grant=%b s_as=%b want 0000/0", m_grant, s_as);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    m_as  = '0;
    m_req = 4'b1111;
    cycle();
    tests++;
    if (m_grant !== 4'b0001) begin
      fails++;
      $display("FAIL midrst_first got=%b want=0001", m_grant);
    end
    m_req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, er;
    logic [SW-1:0] es;
    logic          ewe, eas;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      cycle();
      eg = exp_grant();
      ea = '0; ed = '0; es = '0; ewe = 1'b0; eas = 1'b0; er = '0;
      if (exp_owner >= 0) begin
        ea  = m_addr[exp_owner*AW +: AW];
        ed  = m_wr_data[exp_owner*DW +: DW];
        es  = m_sel[exp_owner*SW +: SW];
        ewe = m_we[exp_owner];
        eas = m_as[exp_owner];
        er  = s_rd_data;
      end
      tests++;
      if ({m_grant, s_addr, s_wr_data, s_sel, s_we, s_as, m_rdy, m_rd_data} !==
          {eg, ea, ed, es, ewe, eas, eg & {N{s_rdy}}, er}) begin
        fails++;
        $display("FAIL random c=%0d grant=%b/%b addr=%h/%h wd=%h/%h sel=%h/%h we=%b/%b as=%b/%b rdy=%b/%b rd=%h/%h",
                 c, m_grant, eg, s_addr, ea, s_wr_data, ed, s_sel, es, s_we, ewe, s_as, eas,
                 m_rdy, eg & {N{s_rdy}}, m_rd_data, er);
      end
      if ($urandom_range(3) == 0) m_req = N'($urandom);
      m_addr    = {$urandom, $urandom, $urandom, $urandom};
      m_wr_data = {$urandom, $urandom, $urandom, $urandom};
      m_sel     = 16'($urandom);
      m_we      = N'($urandom);
      m_as      = N'($urandom);
      s_rd_data = $urandom;
      s_rdy     = 1'($urandom);
    end
    m_req = '0;
    s_rdy = 1'b0;
  endtask

  task automatic test_num_m1();
    int bad = 0;
    addr1 = $urandom;
    @(negedge clk);
    req1 = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (grant1 !== 1'b1) begin
      fails++;
      $display("FAIL m1_grant got=%b want=1", grant1);
    end
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (grant1 !== 1'b1 || s_addr1 !== addr1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL m1_hold bad_cycles=%0d want=0", bad);
    end
    req1 = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (grant1 !== 1'b0 || s_addr1 !== '0) begin
      fails++;
      $display("FAIL m1_release grant=%b s_addr=%h want 0/0", grant1, s_addr1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_req = '0; m_we = '0; m_as = '0; m_addr = '0; m_wr_data = '0; m_sel = '0;
    s_rd_data = '0; s_rdy = 1'b0;
    req1 = 1'b0; we1 = 1'b0; as1 = 1'b0; addr1 = '0; wdat1 = '0; sel1 = '0;
    model_reset();
    test_reset();
    test_two_req();
    test_handoff();
    test_single_master();
    test_reset_mid();
    test_random();
    test_num_m1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
